// File: rtl/wifi_tx_pkg.sv
// Shared definitions for the Wi-Fi TX puncturing buffer: rate codes, FSM
// state encodings, puncture pattern periods and the keep/drop pattern.
package wifi_tx_pkg;

  localparam int unsigned PAT_W = 4;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10,
    RATE_5_6 = 2'b11
  } rate_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [PAT_W-1:0] PER_1_2 = PAT_W'(2);
  localparam logic [PAT_W-1:0] PER_2_3 = PAT_W'(4);
  localparam logic [PAT_W-1:0] PER_3_4 = PAT_W'(6);
  localparam logic [PAT_W-1:0] PER_5_6 = PAT_W'(10);

  // Length of the repeating puncture pattern for a code rate.
  function automatic logic [PAT_W-1:0] pat_period(input rate_t r);
    logic [PAT_W-1:0] p;
    case (r)
      RATE_1_2: p = PER_1_2;
      RATE_2_3: p = PER_2_3;
      RATE_3_4: p = PER_3_4;
      default:  p = PER_5_6;
    endcase
    return p;
  endfunction

  // 1 when the coded bit at pattern position pos is transmitted.
  function automatic logic pat_keep(input rate_t r, input logic [PAT_W-1:0] pos);
    logic k;
    case (r)
      RATE_1_2: k = 1'b1;
      RATE_2_3: k = (pos != PAT_W'(3));
      RATE_3_4: k = !((pos == PAT_W'(3)) || (pos == PAT_W'(4)));
      default:  k = !((pos == PAT_W'(3)) || (pos == PAT_W'(4)) ||
                      (pos == PAT_W'(7)) || (pos == PAT_W'(8)));
    endcase
    return k;
  endfunction

endpackage

// File: rtl/wifi_tx_bit_fifo.sv
// Circular single-bit FIFO with registered read data.
// Ports: clk/reset (async active-low); wr/wr_data write request; rd read
// request; wr_acc_c/rd_acc_c combinational accept strobes; rd_data/rd_valid
// registered read result (one cycle after the accepted read); count fill
// level; full; overflow sticky dropped-write flag.
module wifi_tx_bit_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        wr_data,
  input  logic        rd,
  output logic        wr_acc_c,
  output logic        rd_acc_c,
  output logic        rd_data,
  output logic        rd_valid,
  output logic [AW:0] count,
  output logic        full,
  output logic        overflow
);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;

  // A read at full frees the slot the concurrent write lands in.
  assign rd_acc_c = rd & (count != '0);
  assign wr_acc_c = wr & (~full | rd_acc_c);

  always_comb begin
    count_next = count;
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_data  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc_c) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= rd_acc_c;
      count    <= count_next;
      full     <= (count_next == (AW+1)'(DEPTH));
      if (wr & ~wr_acc_c) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/wifi_tx_puncture_buf.sv
// Buffers convolutionally coded bits and punctures them to the code rate
// latched at frame start.
// Ports: clk; reset (async active-low); valid_in/data_in coded bit input;
// rate code rate; enable downstream read request; valid_out/data_out kept
// bit output (two cycles after the buffer read); finished one-cycle
// end-of-frame pulse; full buffer full; overflow sticky dropped-write flag.
module wifi_tx_puncture_buf
  import wifi_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       data_in,
  input  logic [1:0] rate,
  input  logic       enable,
  output logic       valid_out,
  output logic       data_out,
  output logic       finished,
  output logic       full,
  output logic       overflow
);

  state_t           state;
  state_t           state_next;
  rate_t            rate_q;
  logic [PAT_W-1:0] pat_q;
  logic             keep_q;
  logic             frame_start_c;
  logic             rd_req_c;
  logic             wr_acc_c;
  logic             rd_acc_c;
  logic             rd_data;
  logic             rd_valid;
  logic [AW:0]      count;

  // Reads only drain an open frame; a bit held over from DONE waits for IDLE.
  assign rd_req_c = enable & (state == ST_ACTIVE);

  wifi_tx_bit_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (valid_in),
    .wr_data  (data_in),
    .rd       (rd_req_c),
    .wr_acc_c (wr_acc_c),
    .rd_acc_c (rd_acc_c),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (wr_acc_c || (count != '0)) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (rd_acc_c && !wr_acc_c && (count == (AW+1)'(1))) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM decoded controls.
  always_comb begin
    frame_start_c = 1'b0;
    if ((state == ST_IDLE) && (wr_acc_c || (count != '0))) frame_start_c = 1'b1;
  end

  // Rate latch, pattern position and the keep decision for the bit being read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q <= RATE_1_2;
      pat_q  <= '0;
      keep_q <= 1'b0;
    end else begin
      if (frame_start_c) begin
        rate_q <= rate_t'(rate);
        pat_q  <= '0;
      end else if (rd_acc_c) begin
        keep_q <= pat_keep(rate_q, pat_q);
        if (pat_q == pat_period(rate_q) - PAT_W'(1)) pat_q <= '0;
        else                                         pat_q <= pat_q + PAT_W'(1);
      end
    end
  end

  // Puncture output stage; data_out holds while nothing is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      finished  <= 1'b0;
    end else begin
      valid_out <= rd_valid & keep_q;
      if (rd_valid & keep_q) data_out <= rd_data;
      finished <= (state_next == ST_DONE);
    end
  end

endmodule
